nco_multi: RTL

Parametrised multi-channel numerically controlled oscillator, successor to the single-channel fixed-waveform NCO behind the TinyTapeout top. Each of NCH channels owns a phase accumulator with a run-time frequency tuning word, phase offset, waveform mode and PWM duty, all written through a register port. Each channel drives an unsigned offset-binary sample bus and a wrap pulse. A global sync re-aligns all channel phases.

---
 rtl/nco_pkg.sv | 16 +
 rtl/nco_wave.sv | 56 +++++
 rtl/nco_multi.sv | 59 +++++
 3 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: waveform mode codes, config field codes and level helpers for the NCO
package nco_pkg;
  typedef enum logic [2:0] {
    NCO_SAW, NCO_RAMP, NCO_TRI, NCO_SQUARE, NCO_SINE, NCO_PWM, NCO_DC, NCO_OFF
  } nco_mode_t;
  localparam logic [1:0] CFG_FTW  = 2'd0;
  localparam logic [1:0] CFG_POFF = 2'd1;
  localparam logic [1:0] CFG_MODE = 2'd2;
  localparam logic [1:0] CFG_DUTY = 2'd3;
  function automatic logic [31:0] mid_level(input int w);
    return 32'd1 << (w - 1);
  endfunction
  function automatic logic [31:0] max_level(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction
endpackage

// File: rtl/nco_wave.sv
// nco_wave: combinational phase-to-sample shaper with quarter-wave sine ROM
module nco_wave
  import nco_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 6
) (
  input  logic [ACC_W-1:0] p,
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] sample
);
  localparam logic [OUT_W-1:0] MAX = OUT_W'(max_level(OUT_W));
  localparam logic [OUT_W-1:0] MID = OUT_W'(mid_level(OUT_W));
  logic [OUT_W-1:0] t, u, sine;
  logic [LUT_AW-1:0] q, idx;
  logic [6:0] rom;
  logic [OUT_W-2:0] mag;
  assign t = p[ACC_W-1 -: OUT_W];
  assign u = p[ACC_W-2 -: OUT_W];
  assign q = p[ACC_W-3 -: LUT_AW];
  assign idx = p[ACC_W-2] ? ~q : q;
  assign mag = (OUT_W-1)'(rom);
  assign sine = p[ACC_W-1] ? {1'b0, ~mag} : {1'b1, mag};
  always_comb begin
    rom = '0;
    case (idx)
      6'd0:  rom = 7'd2;   6'd1:  rom = 7'd5;   6'd2:  rom = 7'd8;   6'd3:  rom = 7'd11;
      6'd4:  rom = 7'd14;  6'd5:  rom = 7'd17;  6'd6:  rom = 7'd20;  6'd7:  rom = 7'd23;
      6'd8:  rom = 7'd26;  6'd9:  rom = 7'd29;  6'd10: rom = 7'd32;  6'd11: rom = 7'd35;
      6'd12: rom = 7'd38;  6'd13: rom = 7'd41;  6'd14: rom = 7'd44;  6'd15: rom = 7'd47;
      6'd16: rom = 7'd50;  6'd17: rom = 7'd53;  6'd18: rom = 7'd56;  6'd19: rom = 7'd58;
      6'd20: rom = 7'd61;  6'd21: rom = 7'd64;  6'd22: rom = 7'd67;  6'd23: rom = 7'd69;
      6'd24: rom = 7'd72;  6'd25: rom = 7'd74;  6'd26: rom = 7'd77;  6'd27: rom = 7'd79;
      6'd28: rom = 7'd82;  6'd29: rom = 7'd84;  6'd30: rom = 7'd86;  6'd31: rom = 7'd89;
      6'd32: rom = 7'd91;  6'd33: rom = 7'd93;  6'd34: rom = 7'd95;  6'd35: rom = 7'd97;
      6'd36: rom = 7'd99;  6'd37: rom = 7'd101; 6'd38: rom = 7'd103; 6'd39: rom = 7'd105;
      6'd40: rom = 7'd106; 6'd41: rom = 7'd108; 6'd42: rom = 7'd110; 6'd43: rom = 7'd111;
      6'd44: rom = 7'd113; 6'd45: rom = 7'd114; 6'd46: rom = 7'd115; 6'd47: rom = 7'd117;
      6'd48: rom = 7'd118; 6'd49: rom = 7'd119; 6'd50: rom = 7'd120; 6'd51: rom = 7'd121;
      6'd52: rom = 7'd122; 6'd53: rom = 7'd123; 6'd54: rom = 7'd124; 6'd55: rom = 7'd124;
      6'd56: rom = 7'd125; 6'd57: rom = 7'd125; 6'd58: rom = 7'd126; 6'd59: rom = 7'd126;
      6'd60: rom = 7'd127; 6'd61: rom = 7'd127; 6'd62: rom = 7'd127; 6'd63: rom = 7'd127;
      default: rom = '0;
    endcase
  end
  always_comb
    sample = mode == NCO_SAW    ? t :
             mode == NCO_RAMP   ? ~t :
             mode == NCO_TRI    ? (p[ACC_W-1] ? ~u : u) :
             mode == NCO_SQUARE ? (p[ACC_W-1] ? '0 : MAX) :
             mode == NCO_SINE   ? sine :
             mode == NCO_PWM    ? (t < duty ? MAX : '0) :
             mode == NCO_DC     ? MID : '0;
endmodule

// File: rtl/nco_multi.sv
// nco_multi: multi-channel NCO with per-channel tuning, offset, waveform and duty registers
module nco_multi
  import nco_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 6
) (
  input  logic                    clk_50MHz,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sync_in,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [1:0]              cfg_field,
  input  logic [ACC_W-1:0]        cfg_data,
  output logic [NCH*OUT_W-1:0]    wave_out,
  output logic [NCH-1:0]          wrap
);
  localparam int CW = $clog2(NCH);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [ACC_W-1:0] ftw, poff, acc;
    logic [2:0] mode;
    logic [OUT_W-1:0] duty, sample, q;
    logic [ACC_W:0] sum;
    logic sel, cy, wr_q;
    assign sel = cfg_we && cfg_ch == CW'(c);
    assign sum = {1'b0, acc} + {1'b0, ftw};
    always_ff @(posedge clk_50MHz)
      if (reset) begin
        ftw  <= '0;
        poff <= '0;
        mode <= NCO_SAW;
        duty <= OUT_W'(mid_level(OUT_W));
        acc  <= '0;
        cy   <= 1'b0;
        wr_q <= 1'b0;
        q    <= '0;
      end else begin
        if (sel && cfg_field == CFG_FTW) ftw <= cfg_data;
        if (sel && cfg_field == CFG_POFF) poff <= cfg_data;
        if (sel && cfg_field == CFG_MODE) mode <= cfg_data[2:0];
        if (sel && cfg_field == CFG_DUTY) duty <= cfg_data[OUT_W-1:0];
        acc  <= sync_in ? '0 : enable ? sum[ACC_W-1:0] : acc;
        cy   <= !sync_in && enable && sum[ACC_W];
        wr_q <= cy;
        q    <= sample;
      end
    nco_wave #(.ACC_W(ACC_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) u_wave (
      .p(acc + poff),
      .mode(mode),
      .duty(duty),
      .sample(sample)
    );
    assign wave_out[c*OUT_W +: OUT_W] = q;
    assign wrap[c] = wr_q;
  end
endmodule
